// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory responder with a fixed access
// latency. Takes one read or write per valid/ready handshake, waits
// WAIT_CYCLES cycles, does the access with byte enables at WAIT exit, and
// holds the registered response until the requester consumes it.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    // Counter is at least one bit wide so WAIT_CYCLES = 0 still builds.
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // A request is rejected when it is not word aligned or when any address
    // bit above the array index is set, so out-of-range addresses never alias.
    function automatic logic addr_is_bad(input logic [31:0] addr);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = (addr[31:ADDR_WIDTH+2] != {(30-ADDR_WIDTH){1'b0}});
        return misaligned | out_of_range;
    endfunction

    // Word index into the array for a byte address.
    function automatic logic [ADDR_WIDTH-1:0] word_index(input logic [31:0] addr);
        return addr[ADDR_WIDTH+1:2];
    endfunction

    state_e                state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic                  we_q,         we_d;
    logic [31:0]           addr_q,       addr_d;
    logic [31:0]           wdata_q,      wdata_d;
    logic [3:0]            be_q,         be_d;
    logic                  req_ready_q,  req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           rdata_q,      rdata_d;
    logic                  err_q,        err_d;

    // Storage: deliberately not reset, contents undefined after power-up.
    logic [31:0]           mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] idx_s;
    logic                  addr_bad_s;
    logic [31:0]           rd_word_s;
    logic                  mem_we_s;

    // Decode of the latched request address and the word it selects.
    always_comb begin
        idx_s      = word_index(addr_q);
        addr_bad_s = addr_is_bad(addr_q);
        rd_word_s  = mem_q[idx_s];
    end

    // Next-state, latch and response logic for the IDLE/WAIT/RESP sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_we_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                resp_valid_d = 1'b0;
                if (req_valid_i && req_ready_q) begin
                    we_d        = req_we_i;
                    addr_d      = req_addr_i;
                    wdata_d     = req_wdata_i;
                    be_d        = req_be_i;
                    cnt_d       = CNT_INIT;
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end else begin
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_WAIT: begin
                req_ready_d = 1'b0;
                if (cnt_q != CNT_ZERO) begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = ST_WAIT;
                end else begin
                    // Access happens on the edge that leaves WAIT, so a
                    // write is committed before its response is visible.
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    if (addr_bad_s) begin
                        rdata_d = 32'h0000_0000;
                        err_d   = 1'b1;
                    end else if (we_q) begin
                        rdata_d  = 32'h0000_0000;
                        err_d    = 1'b0;
                        mem_we_s = 1'b1;
                    end else begin
                        rdata_d = rd_word_s;
                        err_d   = 1'b0;
                    end
                end
            end

            ST_RESP: begin
                req_ready_d = 1'b0;
                if (resp_ready_i) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    rdata_d      = 32'h0000_0000;
                    err_d        = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                cnt_d        = CNT_ZERO;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                rdata_d      = 32'h0000_0000;
                err_d        = 1'b0;
            end
        endcase
    end

    // Control and response registers; reset drops any pending request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            we_q         <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            be_q         <= 4'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Byte-enabled array write, one enable per byte lane.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses
// WAIT_CYCLES=0. A transaction-level model (timestamps + word array) predicts
// handshake and response values; one process compares every cycle, and the
// directed sequence adds hand-computed literal checks.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [1:0]  resp_err;
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [31:0] resp_rdata [2];
    logic [3:0]  req_be     [2];

    int n_total = 0;
    int n_bad   = 0;

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_addr_i(req_addr[0]),
        .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0])
    );

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_addr_i(req_addr[1]),
        .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wt(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_total = n_total + 1;
        n_bad   = n_bad + 1;
        $display("FAIL %s: got no event within bound, expected one", name);
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          m_busy  [2];
    int          m_acc   [2];
    bit          m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be    [2];
    logic [31:0] m_rdata [2];
    bit          m_err   [2];
    bit          m_known [2];
    logic [31:0] mmem    [2][256];
    logic [3:0]  mkn     [2][256];

    initial begin
        int          idx;
        logic [31:0] mask;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy[0] = 1'b0;
                m_busy[1] = 1'b0;
            end else begin
                cyc = cyc + 1;
                for (int d = 0; d < 2; d++) begin
                    if (!m_busy[d]) begin
                        if (req_valid[d]) begin
                            m_busy[d]  = 1'b1;
                            m_acc[d]   = cyc;
                            m_we[d]    = req_we[d];
                            m_addr[d]  = req_addr[d];
                            m_wdata[d] = req_wdata[d];
                            m_be[d]    = req_be[d];
                        end
                    end else if (cyc == m_acc[d] + wt(d) + 1) begin
                        if ((m_addr[d] % 32'd4) != 32'd0 || m_addr[d] >= 32'd1024) begin
                            m_err[d] = 1'b1; m_rdata[d] = 32'd0; m_known[d] = 1'b1;
                        end else begin
                            idx = int'(m_addr[d] / 32'd4);
                            m_err[d] = 1'b0;
                            if (m_we[d]) begin
                                mask = 32'd0;
                                for (int i = 0; i < 4; i++)
                                    if (m_be[d][i]) mask = mask | (32'hFF << (8 * i));
                                mmem[d][idx] = (mmem[d][idx] & ~mask) | (m_wdata[d] & mask);
                                mkn[d][idx]  = mkn[d][idx] | m_be[d];
                                m_rdata[d] = 32'd0; m_known[d] = 1'b1;
                            end else begin
                                m_rdata[d] = mmem[d][idx];
                                m_known[d] = (mkn[d][idx] == 4'hF);
                            end
                        end
                    end else if (cyc >= m_acc[d] + wt(d) + 2 && resp_ready[d]) begin
                        m_busy[d] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                ev = m_busy[d] && (cyc >= m_acc[d] + wt(d) + 1);
                check($sformatf("d%0d_req_ready", d), 32'(req_ready[d]), 32'(!m_busy[d]));
                check($sformatf("d%0d_resp_valid", d), 32'(resp_valid[d]), 32'(ev));
                if (ev) begin
                    check($sformatf("d%0d_resp_err", d), 32'(resp_err[d]), 32'(m_err[d]));
                    if (m_known[d])
                        check($sformatf("d%0d_resp_rdata", d), resp_rdata[d], m_rdata[d]);
                end
            end
        end
    end

    // One request through instance d; hold > 0 keeps resp_ready low that many
    // cycles while a competing write to 0x40 is presented and must be ignored.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat);
        bit ok;
        rdata = 32'd0; err = 1'b0; lat = 0;
        @(negedge clk);
        req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
        req_valid[d] = 1'b1; resp_ready[d] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready[d]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin timeout_fail("txn_accept"); req_valid[d] = 1'b0; return; end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        ok = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (resp_valid[d]) begin lat = i; ok = 1'b1; break; end
        end
        if (!ok) begin timeout_fail("txn_resp"); return; end
        rdata = resp_rdata[d];
        err   = resp_err[d];
        for (int h = 0; h < hold; h++) begin
            req_we[d] = 1'b1; req_addr[d] = 32'h40; req_wdata[d] = 32'hFFFF_FFFF;
            req_be[d] = 4'hF; req_valid[d] = 1'b1;
            @(negedge clk);
            check("hold_req_ready", 32'(req_ready[d]), 32'd0);
            check("hold_resp_valid", 32'(resp_valid[d]), 32'd1);
        end
        req_valid[d] = 1'b0;
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        check("ready_after_resp", 32'(req_ready[d]), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] b2b_exp [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

    initial begin
        bit ok;
        int prev_t;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; req_be[d] = 4'h0; resp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", 32'(req_ready[d]), 32'd1);
            check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
            check("rst_resp_rdata", resp_rdata[d], 32'd0);
            check("rst_resp_err", 32'(resp_err[d]), 32'd0);
        end
        rst = 1'b0;

        // Full write then read, WAIT_CYCLES = 2
        txn(0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 0, rd, er, lat);
        check("wr40_rdata", rd, 32'd0);
        check("wr40_err", 32'(er), 32'd0);
        check("wr40_latency", 32'(lat), 32'd4);
        txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 0, rd, er, lat);
        check("rd40_rdata", rd, 32'h1234_5678);
        check("rd40_err", 32'(er), 32'd0);
        check("rd40_latency", 32'(lat), 32'd4);

        // Byte enables, then an all-disabled write that must change nothing
        txn(0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'hF, 0, rd, er, lat);
        txn(0, 1'b1, 32'h8, 32'h1122_3344, 4'b0101, 0, rd, er, lat);
        txn(0, 1'b0, 32'h8, 32'd0, 4'h0, 0, rd, er, lat);
        check("be_merge", rd, 32'hAA22_CC44);
        txn(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, 0, rd, er, lat);
        check("be_zero_err", 32'(er), 32'd0);
        txn(0, 1'b0, 32'h8, 32'd0, 4'h0, 0, rd, er, lat);
        check("be_zero_keep", rd, 32'hAA22_CC44);

        // Errors: misaligned, one past the top, high address bit
        txn(0, 1'b1, 32'h0, 32'h55AA_55AA, 4'hF, 0, rd, er, lat);
        txn(0, 1'b0, 32'h3FE, 32'd0, 4'h0, 0, rd, er, lat);
        check("misalign_err", 32'(er), 32'd1);
        check("misalign_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h400, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
        check("range_err", 32'(er), 32'd1);
        check("range_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h8000_0000, 32'd0, 4'h0, 0, rd, er, lat);
        check("highbit_err", 32'(er), 32'd1);
        txn(0, 1'b0, 32'h0, 32'd0, 4'h0, 0, rd, er, lat);
        check("no_alias_rd0", rd, 32'h55AA_55AA);
        check("no_alias_err", 32'(er), 32'd0);

        // Backpressure: 5 cycles of resp_ready low with a competing write
        txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 5, rd, er, lat);
        check("bp_rdata", rd, 32'h1234_5678);
        txn(0, 1'b0, 32'h40, 32'd0, 4'h0, 0, rd, er, lat);
        check("bp_ignored_write", rd, 32'h1234_5678);

        // Reset during WAIT drops the pending write
        txn(0, 1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, 0, rd, er, lat);
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'hDEAD_BEEF;
        req_be[0] = 4'hF; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midwait_rst_ready", 32'(req_ready[0]), 32'd1);
        check("midwait_rst_valid", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er, lat);
        check("midwait_keep_old", rd, 32'h0BAD_F00D);
        check("midwait_not_new", 32'(rd != 32'hDEAD_BEEF), 32'd1);

        // WAIT_CYCLES = 0: preload, then 4 back-to-back reads
        for (int k = 0; k < 4; k++) begin
            txn(1, 1'b1, 32'h100 + 32'(4 * k), b2b_exp[k], 4'hF, 0, rd, er, lat);
            check("w0_write_latency", 32'(lat), 32'd2);
        end
        @(negedge clk);
        resp_ready[1] = 1'b1;
        prev_t = 0;
        for (int k = 0; k < 4; k++) begin
            req_we[1] = 1'b0; req_addr[1] = 32'h100 + 32'(4 * k); req_be[1] = 4'h0;
            req_valid[1] = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (req_ready[1]) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (!ok) begin timeout_fail("b2b_accept"); break; end
            @(posedge clk); #1;
            req_valid[1] = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (resp_valid[1]) begin ok = 1'b1; break; end
            end
            if (!ok) begin timeout_fail("b2b_resp"); break; end
            check($sformatf("b2b_data%0d", k), resp_rdata[1], b2b_exp[k]);
            if (k > 0) check("b2b_interval", 32'(cyc - prev_t), 32'd3);
            prev_t = cyc;
        end
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
